// File: rtl/enc_tx_sched.sv
// Two-requester frame scheduler that feeds an 8b/10b encoder. It handles link
// bring-up, round-robin framing (K27.7 / K29.7), alignment and filler insertion.
module enc_tx_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        link_en,
  input  logic [11:0] align_period,
  input  logic        a_valid,
  input  logic [7:0]  a_data,
  input  logic        a_last,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [7:0]  b_data,
  input  logic        b_last,
  output logic        b_ready,
  output logic [7:0]  enc_datain,
  output logic        enc_kin,
  output logic        enc_ena,
  output logic        enc_idle_ins,
  output logic        enc_rdforce,
  output logic        enc_rdin,
  output logic [2:0]  sched_state,
  output logic        underrun
);

  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    INIT     = 3'd1,
    IDLE     = 3'd2,
    SOF      = 3'd3,
    DATA     = 3'd4,
    EOF      = 3'd5
  } state_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;

  state_t      state, next_state;
  logic        grant_b, next_grant_b;
  logic        last_grant_b, next_last_grant_b;
  logic [11:0] align_cnt;
  logic [3:0]  init_cnt;

  logic        sel_valid;
  logic [7:0]  sel_data;
  logic        sel_last;
  logic        align_due;
  logic        ready_int;

  logic [7:0]  d_data;
  logic        d_kin;
  logic        d_ena;
  logic        d_idle_ins;
  logic        d_rdforce;
  logic        d_underrun;
  logic        d_k28_5;

  assign sel_valid = grant_b ? b_valid : a_valid;
  assign sel_data  = grant_b ? b_data  : a_data;
  assign sel_last  = grant_b ? b_last  : a_last;

  assign align_due = (state == DATA) && (align_period != 12'd0) &&
                     (align_cnt >= align_period);

  // Ready drops in the same cycle as link_en or reset so a byte is never
  // accepted into a frame that is being abandoned.
  assign ready_int = (state == DATA) && !align_due && link_en && !reset;
  assign a_ready   = ready_int && !grant_b;
  assign b_ready   = ready_int && grant_b;

  assign sched_state = state;

  always_comb begin
    next_state        = state;
    next_grant_b      = grant_b;
    next_last_grant_b = last_grant_b;
    d_data            = 8'h00;
    d_kin             = 1'b0;
    d_ena             = 1'b0;
    d_idle_ins        = 1'b0;
    d_rdforce         = 1'b0;
    d_underrun        = 1'b0;
    d_k28_5           = 1'b0;

    if (!link_en) begin
      next_state = DISABLED;
    end else begin
      case (state)
        DISABLED: next_state = INIT;
        INIT: begin
          d_data    = K28_5;
          d_kin     = 1'b1;
          d_ena     = 1'b1;
          d_rdforce = (init_cnt == 4'd0);
          d_k28_5   = 1'b1;
          if (init_cnt == 4'd15) next_state = IDLE;
        end
        IDLE: begin
          d_idle_ins = 1'b1;
          d_k28_5    = 1'b1;
          if (a_valid || b_valid) begin
            // On a tie the requester that did not win last time goes next.
            next_grant_b      = (a_valid && b_valid) ? !last_grant_b : b_valid;
            next_last_grant_b = next_grant_b;
            next_state        = SOF;
          end
        end
        SOF: begin
          d_data     = K27_7;
          d_kin      = 1'b1;
          d_ena      = 1'b1;
          next_state = DATA;
        end
        DATA: begin
          d_ena = 1'b1;
          if (align_due) begin
            d_data  = K28_5;
            d_kin   = 1'b1;
            d_k28_5 = 1'b1;
          end else if (sel_valid) begin
            d_data = sel_data;
            if (sel_last) next_state = EOF;
          end else begin
            d_data     = K28_5;
            d_kin      = 1'b1;
            d_k28_5    = 1'b1;
            d_underrun = 1'b1;
          end
        end
        EOF: begin
          d_data     = K29_7;
          d_kin      = 1'b1;
          d_ena      = 1'b1;
          next_state = IDLE;
        end
        default: next_state = DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= DISABLED;
      grant_b      <= 1'b0;
      last_grant_b <= 1'b1;
      align_cnt    <= 12'd0;
      init_cnt     <= 4'd0;
      enc_datain   <= 8'h00;
      enc_kin      <= 1'b0;
      enc_ena      <= 1'b0;
      enc_idle_ins <= 1'b0;
      enc_rdforce  <= 1'b0;
      enc_rdin     <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state        <= next_state;
      grant_b      <= next_grant_b;
      last_grant_b <= next_last_grant_b;
      if (d_k28_5)
        align_cnt <= 12'd0;
      else if (align_cnt != 12'hFFF)
        align_cnt <= align_cnt + 12'd1;
      init_cnt     <= (state == INIT && link_en) ? init_cnt + 4'd1 : 4'd0;
      enc_datain   <= d_data;
      enc_kin      <= d_kin;
      enc_ena      <= d_ena;
      enc_idle_ins <= d_idle_ins;
      enc_rdforce  <= d_rdforce;
      enc_rdin     <= 1'b0;
      underrun     <= d_underrun;
    end
  end

endmodule

// File: tb/tb_enc_tx_sched.sv
// Bench for enc_tx_sched: directed bring-up/framing scenarios followed by random
// traffic, all compared cycle by cycle against a rule-level reference model.
module tb_enc_tx_sched;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        link_en;
  logic [11:0] align_period;
  logic        a_valid, a_last, a_ready;
  logic [7:0]  a_data;
  logic        b_valid, b_last, b_ready;
  logic [7:0]  b_data;
  logic [7:0]  enc_datain;
  logic        enc_kin, enc_ena, enc_idle_ins, enc_rdforce, enc_rdin;
  logic [2:0]  sched_state;
  logic        underrun;

  enc_tx_sched dut (
    .clk(clk), .reset(reset), .link_en(link_en), .align_period(align_period),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .enc_datain(enc_datain), .enc_kin(enc_kin), .enc_ena(enc_ena),
    .enc_idle_ins(enc_idle_ins), .enc_rdforce(enc_rdforce), .enc_rdin(enc_rdin),
    .sched_state(sched_state), .underrun(underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Knobs set by the scenarios and driven onto the DUT by applyStimulus.
  logic        drv_reset = 1'b1;
  logic        drv_link  = 1'b0;
  logic [11:0] drv_ap    = 12'd0;
  int          a_prob    = 100;
  int          b_prob    = 100;

  beat_t       aq[$];
  beat_t       bq[$];
  logic [7:0]  sent_q[$];
  int          und_seen = 0;

  // Reference model: states numbered as in the requirement list.
  int          m_state = 0;
  int          m_grant = 0;
  int          m_last  = 1;
  int          m_cnt   = 0;
  int          m_init  = 0;
  logic [7:0]  x_data  = 8'h00;
  logic        x_kin = 1'b0, x_ena = 1'b0, x_idle = 1'b0, x_rdf = 1'b0, x_und = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pushFrame(input int who, input int len);
    beat_t bt;
    for (int i = 0; i < len; i++) begin
      bt.d = 8'($urandom);
      bt.l = (i == len - 1);
      if (who == 0) aq.push_back(bt); else bq.push_back(bt);
    end
  endtask

  task automatic applyStimulus();
    logic       due, rdy, gv, gl;
    logic [7:0] gd;
    int         ns;
    logic [7:0] n_data;
    logic       n_kin, n_ena, n_idle, n_rdf, n_und, k285;

    @(negedge clk);
    checkOutput("sched_state", 32'(sched_state), 32'(m_state));
    checkOutput("enc_datain",  32'(enc_datain),  32'(x_data));
    checkOutput("enc_kin",     32'(enc_kin),     32'(x_kin));
    checkOutput("enc_ena",     32'(enc_ena),     32'(x_ena));
    checkOutput("enc_idle_ins",32'(enc_idle_ins),32'(x_idle));
    checkOutput("enc_rdforce", 32'(enc_rdforce), 32'(x_rdf));
    checkOutput("enc_rdin",    32'(enc_rdin),    32'd0);
    checkOutput("underrun",    32'(underrun),    32'(x_und));
    if (underrun === 1'b1) und_seen++;
    if (enc_ena === 1'b1 && enc_kin === 1'b0) begin
      if (sent_q.size() == 0) checkOutput("stream_extra_byte", 32'(enc_datain), 32'hFFFF_FFFF);
      else checkOutput("stream_byte", 32'(enc_datain), 32'(sent_q.pop_front()));
    end

    reset        = drv_reset;
    link_en      = drv_link;
    align_period = drv_ap;
    a_valid      = (aq.size() > 0) && ($urandom_range(99) < a_prob);
    a_data       = (aq.size() > 0) ? aq[0].d : 8'($urandom);
    a_last       = (aq.size() > 0) ? aq[0].l : 1'($urandom);
    b_valid      = (bq.size() > 0) && ($urandom_range(99) < b_prob);
    b_data       = (bq.size() > 0) ? bq[0].d : 8'($urandom);
    b_last       = (bq.size() > 0) ? bq[0].l : 1'($urandom);
    #1;

    due = (m_state == 4) && (drv_ap != 0) && (m_cnt >= int'(drv_ap));
    rdy = !drv_reset && drv_link && (m_state == 4) && !due;
    checkOutput("a_ready", 32'(a_ready), 32'(rdy && m_grant == 0));
    checkOutput("b_ready", 32'(b_ready), 32'(rdy && m_grant == 1));

    gv = (m_grant == 1) ? b_valid : a_valid;
    gd = (m_grant == 1) ? b_data  : a_data;
    gl = (m_grant == 1) ? b_last  : a_last;

    if (rdy && gv) begin
      if (m_grant == 1) void'(bq.pop_front()); else void'(aq.pop_front());
    end

    if (drv_reset) begin
      m_state = 0; m_grant = 0; m_last = 1; m_cnt = 0; m_init = 0;
      x_data = 8'h00; x_kin = 0; x_ena = 0; x_idle = 0; x_rdf = 0; x_und = 0;
    end else begin
      ns = m_state;
      n_data = 8'h00; n_kin = 0; n_ena = 0; n_idle = 0; n_rdf = 0; n_und = 0; k285 = 0;
      if (!drv_link) ns = 0;
      else begin
        case (m_state)
          0: ns = 1;
          1: begin
            n_data = 8'hBC; n_kin = 1; n_ena = 1; k285 = 1;
            n_rdf = (m_init == 0);
            if (m_init == 15) ns = 2;
          end
          2: begin
            n_idle = 1; k285 = 1;
            if (a_valid || b_valid) begin
              if (a_valid && b_valid) m_grant = 1 - m_last;
              else m_grant = b_valid ? 1 : 0;
              m_last = m_grant;
              ns = 3;
            end
          end
          3: begin n_data = 8'hFB; n_kin = 1; n_ena = 1; ns = 4; end
          4: begin
            n_ena = 1;
            if (due) begin n_data = 8'hBC; n_kin = 1; k285 = 1; end
            else if (gv) begin
              n_data = gd;
              sent_q.push_back(gd);
              if (gl) ns = 5;
            end else begin n_data = 8'hBC; n_kin = 1; k285 = 1; n_und = 1; end
          end
          5: begin n_data = 8'hFD; n_kin = 1; n_ena = 1; ns = 2; end
          default: ns = 0;
        endcase
      end
      m_init = (m_state == 1 && drv_link) ? (m_init + 1) % 16 : 0;
      m_cnt  = k285 ? 0 : ((m_cnt + 1 > 4095) ? 4095 : m_cnt + 1);
      m_state = ns;
      x_data = n_data; x_kin = n_kin; x_ena = n_ena; x_idle = n_idle;
      x_rdf = n_rdf; x_und = n_und;
    end
  endtask

  initial begin
    reset = 1'b1; link_en = 1'b0; align_period = 12'd0;
    a_valid = 0; a_data = 0; a_last = 0; b_valid = 0; b_data = 0; b_last = 0;

    // Reset, then link bring-up through INIT into IDLE.
    repeat (3) applyStimulus();
    drv_reset = 1'b0;
    repeat (2) applyStimulus();
    drv_link = 1'b1;
    repeat (22) applyStimulus();

    // Single three-byte frame from A.
    aq.push_back('{d: 8'h11, l: 1'b0});
    aq.push_back('{d: 8'h22, l: 1'b0});
    aq.push_back('{d: 8'h33, l: 1'b1});
    repeat (10) applyStimulus();

    // Both requesters with two frames each: grants must alternate A,B,A,B.
    pushFrame(0, 2); pushFrame(0, 3);
    pushFrame(1, 3); pushFrame(1, 2);
    repeat (30) applyStimulus();

    // Alignment insertion while A streams ten bytes without gaps.
    drv_ap = 12'd4;
    pushFrame(0, 10);
    repeat (25) applyStimulus();
    drv_ap = 12'd0;
    repeat (3) applyStimulus();

    // Two-cycle valid gap mid-frame produces exactly two fillers.
    und_seen = 0;
    pushFrame(0, 6);
    repeat (4) applyStimulus();
    a_prob = 0;
    repeat (2) applyStimulus();
    a_prob = 100;
    repeat (12) applyStimulus();
    checkOutput("underrun_pulses", 32'(und_seen), 32'd2);

    // Link drop in the middle of a frame, then full re-initialisation.
    pushFrame(1, 8);
    repeat (5) applyStimulus();
    drv_link = 1'b0;
    repeat (3) applyStimulus();
    drv_link = 1'b1;
    repeat (35) applyStimulus();

    // Random traffic with link drops, reset pulses and varying align period.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 500 == 0) begin
        case ($urandom_range(3))
          0: drv_ap = 12'd0;
          1: drv_ap = 12'd2;
          2: drv_ap = 12'd5;
          default: drv_ap = 12'd13;
        endcase
      end
      a_prob = 70; b_prob = 70;
      if (aq.size() == 0 && $urandom_range(9) == 0) pushFrame(0, $urandom_range(1, 6));
      if (bq.size() == 0 && $urandom_range(9) == 0) pushFrame(1, $urandom_range(1, 6));
      drv_link  = ($urandom_range(199) != 0);
      drv_reset = ($urandom_range(499) == 0);
      applyStimulus();
    end

    // Drain everything still queued and confirm the output stream caught up.
    drv_reset = 1'b0; drv_link = 1'b1; drv_ap = 12'd0; a_prob = 100; b_prob = 100;
    repeat (120) applyStimulus();
    checkOutput("a_queue_drained", 32'(aq.size()), 32'd0);
    checkOutput("b_queue_drained", 32'(bq.size()), 32'd0);
    checkOutput("stream_drained", 32'(sent_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/enc_tx_sched.md
ENC_TX_SCHED -- requirements
Module: enc_tx_sched

Interface
REQ-001 clk  in  1  single clock; all state changes on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 link_en  in  1  link enable; low forces DISABLED.
REQ-004 align_period  in  12  max cycles between K28.5 symbols; 0 disables mid-frame alignment insertion.
REQ-005 a_valid / a_data / a_last  in  1/8/1  requester A byte stream; a_last marks final byte of frame.
REQ-006 a_ready  out  1  requester A byte accepted when a_valid & a_ready.
REQ-007 b_valid / b_data / b_last / b_ready  in/in/in/out  1/8/1/1  requester B, same rules as A.
REQ-008 enc_datain  out  8  byte to encoder.
REQ-009 enc_kin  out  1  enc_datain is a K character.
REQ-010 enc_ena  out  1  encoder input valid.
REQ-011 enc_idle_ins  out  1  request encoder idle insertion (encoder emits K28.5 when enc_ena=0).
REQ-012 enc_rdforce / enc_rdin  out  1/1  force encoder running disparity to enc_rdin.
REQ-013 sched_state  out  3  current FSM state encoding.
REQ-014 underrun  out  1  one-cycle pulse per filler inserted mid-frame due to missing data.

Function
REQ-015 States: DISABLED=0, INIT=1, IDLE=2, SOF=3, DATA=4, EOF=5; sched_state shall equal current state.
REQ-016 All enc_* outputs and underrun shall be registered: they reflect the decision of the previous cycle (1-cycle latency).
REQ-017 DISABLED: enc_ena=0, enc_idle_ins=0; go to INIT when link_en=1.
REQ-018 INIT: 16 cycles of K28.5 (enc_datain=0xBC, enc_kin=1, enc_ena=1); enc_rdforce=1, enc_rdin=0 on first INIT cycle only; then IDLE.
REQ-019 IDLE: enc_ena=0, enc_idle_ins=1; if any valid, grant one requester and go SOF.
REQ-020 Arbitration: round-robin at frame boundaries only; if both valid, grant the one not granted last; grant held until EOF.
REQ-021 SOF: emit K27.7 (0xFB, kin=1, ena=1) for one cycle; go DATA.
REQ-022 DATA: ready of granted requester = 1 unless align due; the other ready = 0 in all states.
REQ-023 Accepted byte shall appear on enc_datain with enc_kin=0, enc_ena=1 the next cycle.
REQ-024 DATA with granted valid=0: emit filler K28.5 (kin=1, ena=1) and pulse underrun.
REQ-025 Align due when align_period!=0 and align counter >= align_period while in DATA: ready=0 that cycle, emit K28.5, no underrun pulse.
REQ-026 Align counter: 12-bit, increments every cycle, saturates at 4095, clears on any cycle emitting K28.5 (INIT, IDLE, filler, align).
REQ-027 Acceptance with last=1 -> EOF: emit K29.7 (0xFD, kin=1, ena=1) one cycle; then IDLE (minimum one idle cycle between frames).
REQ-028 link_en=0 in any state -> DISABLED next cycle; frame abandoned, no EOF, ready=0 immediately (combinational on link_en).
REQ-029 Zero-length frames not supported; a frame has at least one data byte.

Reset
REQ-030 On reset: state DISABLED, all outputs 0, align counter 0, last-grant=B (A wins first tie).
REQ-031 Reset asserted mid-frame shall abort the frame identically to REQ-028 and take priority over all inputs.

Verification
REQ-032 Reset, link_en=1 -> 16 cycles enc_datain=0xBC kin=1, enc_rdforce=1 only first cycle, then enc_idle_ins=1 enc_ena=0.
REQ-033 A sends 3 bytes 0x11,0x22,0x33(last) -> enc stream 0xFB(K),0x11,0x22,0x33,0xFD(K), then idle.
REQ-034 A and B valid simultaneously in IDLE, two frames each -> order A,B,A,B; losing ready held 0 throughout.
REQ-035 align_period=4, A streams 10 bytes continuously -> 0xBC(K) inserted after every 4 counted cycles, a_ready=0 on those cycles, no byte lost.
REQ-036 a_valid drops 2 cycles mid-frame -> two 0xBC fillers, underrun pulses twice, then data resumes.
REQ-037 link_en deasserted mid-DATA -> next cycle DISABLED, enc_ena=0, no 0xFD; re-enable -> full INIT sequence.
